cache_lookup_ctrl: RTL and testbench

- Request-side lookup stage of the fully associative cache. It sits directly upstream of the cache data fetcher.
- Accepts CPU read requests and compares the request tag against every way's tag and valid bit.
- Drives the one-hot target-way vector consumed by the data fetcher and returns the fetched word to the CPU.
- On a miss, issues a fill request and waits for fill completion. It then replays the lookup.

---
 rtl/cache_lookup_pkg.sv | 20 ++
 rtl/onehot_priority_select.sv | 17 +
 rtl/cache_lookup_ctrl.sv | 124 ++++++++++++
 tb/tb_cache_lookup_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_lookup_pkg.sv
// Shared state encoding, counter limits and tag helper for the cache lookup path.
package cache_lookup_pkg;

    localparam int CNT_WIDTH = 32;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        RESPOND   = 3'd2,
        MISS_REQ  = 3'd3,
        FILL_WAIT = 3'd4
    } lookup_state_e;

    // Callers truncate the result to their own tag width.
    function automatic logic [63:0] tag_of(input logic [63:0] addr, input int offsetBits);
        return addr >> offsetBits;
    endfunction

endpackage

// File: rtl/onehot_priority_select.sv
// Lowest-index set bit of vec as a one-hot vector, plus any/multiple-set flags.
// Purely combinational; no latency, no flow control.
module onehot_priority_select #(
    parameter int NUM_WAYS = 512
) (
    input  logic [NUM_WAYS-1:0] vec,
    output logic [NUM_WAYS-1:0] onehot,
    output logic                any,
    output logic                multi
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = vec & (~vec + NUM_WAYS'(1));
    assign any    = |vec;
    assign multi  = |(vec & ~onehot);

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Fully associative lookup stage: tag compare, one-hot way select, miss/fill/replay.
// Hit response two cycles after acceptance; response and miss request hold until their ready.
module cache_lookup_ctrl
    import cache_lookup_pkg::*;
#(
    parameter int NUM_WAYS    = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_WIDTH   = ADDR_WIDTH - OFFSET_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reqValid,
    output logic                          reqReady,
    input  logic [ADDR_WIDTH-1:0]         reqAddr,
    input  logic [NUM_WAYS-1:0]           wayValid,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0] wayTags,
    output logic [NUM_WAYS-1:0]           targetWay,
    input  logic [DATA_WIDTH-1:0]         fetchedData,
    output logic                          rspValid,
    input  logic                          rspReady,
    output logic [DATA_WIDTH-1:0]         rspData,
    output logic                          missValid,
    input  logic                          missReady,
    output logic [ADDR_WIDTH-1:0]         missAddr,
    input  logic                          fillDone,
    output logic                          multiHitErr,
    output logic [CNT_WIDTH-1:0]          hitCount,
    output logic [CNT_WIDTH-1:0]          missCount
);

    lookup_state_e         state;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic                  replay;
    logic [TAG_WIDTH-1:0]  reqTag;
    logic [NUM_WAYS-1:0]   matchVec;
    logic [NUM_WAYS-1:0]   hitOnehot;
    logic                  hitAny;
    logic                  hitMulti;

    assign reqTag = TAG_WIDTH'(tag_of(64'(addrReg), OFFSET_BITS));

    always_comb begin
        matchVec = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            matchVec[i] = wayValid[i] && (wayTags[i*TAG_WIDTH +: TAG_WIDTH] == reqTag);
        end
    end

    onehot_priority_select #(
        .NUM_WAYS (NUM_WAYS)
    ) uPrioritySelect (
        .vec    (matchVec),
        .onehot (hitOnehot),
        .any    (hitAny),
        .multi  (hitMulti)
    );

    assign reqReady  = (state == IDLE);
    assign rspValid  = (state == RESPOND);
    assign rspData   = (state == RESPOND) ? fetchedData : '0;
    assign missValid = (state == MISS_REQ);
    assign missAddr  = {addrReg[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addrReg     <= '0;
            replay      <= 1'b0;
            targetWay   <= '0;
            multiHitErr <= 1'b0;
            hitCount    <= '0;
            missCount   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        addrReg <= reqAddr;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    targetWay <= hitOnehot;
                    if (hitMulti) begin
                        multiHitErr <= 1'b1;
                    end
                    if (hitAny) begin
                        state <= RESPOND;
                        if (hitCount != CNT_MAX) begin
                            hitCount <= hitCount + CNT_WIDTH'(1);
                        end
                    end else begin
                        state <= MISS_REQ;
                        // A replay that misses again was already counted once.
                        if (!replay && missCount != CNT_MAX) begin
                            missCount <= missCount + CNT_WIDTH'(1);
                        end
                    end
                end
                RESPOND: begin
                    if (rspReady) begin
                        state     <= IDLE;
                        targetWay <= '0;
                        replay    <= 1'b0;
                    end
                end
                MISS_REQ: begin
                    if (missReady) begin
                        state <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (fillDone) begin
                        state  <= COMPARE;
                        replay <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Bench for cache_lookup_ctrl with four ways: directed vector table, random transactions, saturation and reset cases.
module tb_cache_lookup_ctrl;

    localparam int NW = 4;
    localparam int TW = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [31:0]   reqAddr = '0;
    logic [NW-1:0] wayValid = '0;
    logic [NW*TW-1:0] wayTags = '0;
    logic [NW-1:0] targetWay;
    logic [31:0]   fetchedData;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [31:0]   rspData;
    logic          missValid;
    logic          missReady = 1'b0;
    logic [31:0]   missAddr;
    logic          fillDone = 1'b0;
    logic          multiHitErr;
    logic [31:0]   hitCount;
    logic [31:0]   missCount;

    logic [31:0]   wayData [NW];

    int errors = 0;
    int checks = 0;

    logic [31:0] mdlHit = '0;
    logic [31:0] mdlMiss = '0;
    bit          mdlMulti = 1'b0;

    cache_lookup_ctrl #(
        .NUM_WAYS    (NW),
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .OFFSET_BITS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqAddr     (reqAddr),
        .wayValid    (wayValid),
        .wayTags     (wayTags),
        .targetWay   (targetWay),
        .fetchedData (fetchedData),
        .rspValid    (rspValid),
        .rspReady    (rspReady),
        .rspData     (rspData),
        .missValid   (missValid),
        .missReady   (missReady),
        .missAddr    (missAddr),
        .fillDone    (fillDone),
        .multiHitErr (multiHitErr),
        .hitCount    (hitCount),
        .missCount   (missCount)
    );

    always #5 clk = ~clk;

    // Stand-in data fetcher: OR of the data of every selected way.
    always_comb begin
        fetchedData = '0;
        for (int i = 0; i < NW; i++) begin
            if (targetWay[i]) fetchedData = fetchedData | wayData[i];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wv;
        logic [29:0] tags [4];
        int          rspDelay;
        int          missDelay;
        int          fillWay;
        int          expWay;
        bit          expMulti;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] satInc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Reference lookup: scan ways in ascending order, first valid tag match wins.
    task automatic modelLookup(input logic [31:0] addr, output int way, output bit multi);
        int n = 0;
        way = -1;
        for (int i = 0; i < NW; i++) begin
            if (wayValid[i] && wayTags[i*TW +: TW] == addr[31:2]) begin
                if (way < 0) way = i;
                n++;
            end
        end
        multi = (n > 1);
    endtask

    task automatic addVec(input logic [31:0] addr, input logic [3:0] wv,
                          input logic [29:0] t0, input logic [29:0] t1,
                          input logic [29:0] t2, input logic [29:0] t3,
                          input int rd, input int md, input int fw,
                          input int ew, input bit em);
        vec_t v;
        v.addr = addr; v.wv = wv;
        v.tags[0] = t0; v.tags[1] = t1; v.tags[2] = t2; v.tags[3] = t3;
        v.rspDelay = rd; v.missDelay = md; v.fillWay = fw;
        v.expWay = ew; v.expMulti = em;
        vecs.push_back(v);
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_reqReady"}, 32'(reqReady), 32'd1);
        chk({tag, "_rspValid"}, 32'(rspValid), 32'd0);
        chk({tag, "_rspData"}, rspData, 32'd0);
        chk({tag, "_targetWay"}, 32'(targetWay), 32'd0);
    endtask

    // One full read: request, optional miss/fill/replay, held response, handshake.
    task automatic runTxn(input logic [31:0] addr, input int rspDelay, input int missDelay,
                          input int fillWay, input int expWay, input bit expMulti);
        int way;
        bit m;
        way = expWay;
        chk("reqReady_idle", 32'(reqReady), 32'd1);
        reqAddr = addr;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        reqAddr = $urandom;
        chk("reqReady_compare", 32'(reqReady), 32'd0);
        chk("rspValid_compare", 32'(rspValid), 32'd0);
        if (expMulti) mdlMulti = 1'b1;
        if (way < 0) begin
            tick();
            mdlMiss = satInc(mdlMiss);
            chk("missValid", 32'(missValid), 32'd1);
            chk("missAddr", missAddr, {addr[31:2], 2'b00});
            chk("missCount", missCount, mdlMiss);
            chk("targetWay_miss", 32'(targetWay), 32'd0);
            chk("multiHitErr_miss", 32'(multiHitErr), 32'(mdlMulti));
            for (int c = 0; c < missDelay; c++) begin
                fillDone = (c == 0);
                reqValid = 1'b1;
                tick();
                fillDone = 1'b0;
                reqValid = 1'b0;
                chk("missValid_hold", 32'(missValid), 32'd1);
                chk("missAddr_hold", missAddr, {addr[31:2], 2'b00});
                chk("reqReady_miss", 32'(reqReady), 32'd0);
            end
            missReady = 1'b1;
            tick();
            missReady = 1'b0;
            chk("missValid_fillwait", 32'(missValid), 32'd0);
            chk("rspValid_fillwait", 32'(rspValid), 32'd0);
            wayValid[fillWay] = 1'b1;
            wayTags[fillWay*TW +: TW] = addr[31:2];
            fillDone = 1'b1;
            tick();
            fillDone = 1'b0;
            modelLookup(addr, way, m);
            if (m) mdlMulti = 1'b1;
        end
        tick();
        mdlHit = satInc(mdlHit);
        chk("rspValid", 32'(rspValid), 32'd1);
        chk("targetWay", 32'(targetWay), 32'd1 << way);
        chk("rspData", rspData, wayData[way]);
        chk("hitCount", hitCount, mdlHit);
        chk("missCount_rsp", missCount, mdlMiss);
        chk("multiHitErr", 32'(multiHitErr), 32'(mdlMulti));
        for (int c = 0; c < rspDelay; c++) begin
            reqValid = 1'b1;
            tick();
            chk("rspValid_hold", 32'(rspValid), 32'd1);
            chk("rspData_hold", rspData, wayData[way]);
            chk("targetWay_hold", 32'(targetWay), 32'd1 << way);
            chk("reqReady_rsp", 32'(reqReady), 32'd0);
        end
        reqValid = 1'b0;
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkIdle("after_rsp");
    endtask

    task automatic loadWays(input logic [3:0] wv, input logic [29:0] tags [4]);
        wayValid = wv;
        for (int i = 0; i < NW; i++) wayTags[i*TW +: TW] = tags[i];
    endtask

    initial begin
        wayData[0] = 32'h1111_0000;
        wayData[1] = 32'h2222_0001;
        wayData[2] = 32'hDEAD_BEEF;
        wayData[3] = 32'h4444_0003;

        tick();
        tick();
        chk("reset_hitCount", hitCount, 32'd0);
        chk("reset_missCount", missCount, 32'd0);
        chk("reset_missValid", 32'(missValid), 32'd0);
        chk("reset_multiHitErr", 32'(multiHitErr), 32'd0);
        checkIdle("reset");
        rst = 1'b0;
        tick();

        //     addr          wv       t0      t1      t2      t3    rd md fw  way multi
        addVec(32'h0000_0100, 4'b0100, 30'h0,   30'h0,   30'h40,  30'h0,   0, 0, 0,  2, 0);
        addVec(32'h0000_0204, 4'b0000, 30'h0,   30'h0,   30'h0,   30'h0,   0, 0, 0, -1, 0);
        addVec(32'h0000_0300, 4'b1010, 30'h0,   30'hC0,  30'h0,   30'hC0,  0, 0, 0,  1, 1);
        addVec(32'h0000_0400, 4'b0001, 30'h100, 30'h0,   30'h0,   30'h0,   0, 0, 0,  0, 0);
        addVec(32'h0000_0404, 4'b0100, 30'h0,   30'h0,   30'h101, 30'h0,   5, 0, 0,  2, 0);
        addVec(32'h0000_010F, 4'b1111, 30'h42,  30'h41,  30'hC3,  30'h44,  0, 5, 3, -1, 0);
        addVec(32'h0000_0500, 4'b0100, 30'h0,   30'h140, 30'h140, 30'h140, 0, 0, 0,  2, 0);
        addVec(32'h0000_0600, 4'b1111, 30'h180, 30'h180, 30'h180, 30'h180, 2, 0, 0,  0, 1);

        foreach (vecs[k]) begin
            loadWays(vecs[k].wv, vecs[k].tags);
            runTxn(vecs[k].addr, vecs[k].rspDelay, vecs[k].missDelay,
                   vecs[k].fillWay, vecs[k].expWay, vecs[k].expMulti);
        end

        // Random transactions drawn from a small tag pool so hits, misses and multi-hits all occur.
        for (int n = 0; n < 30; n++) begin
            logic [29:0] tags [4];
            logic [31:0] addr;
            int ew;
            bit em;
            for (int i = 0; i < NW; i++) begin
                tags[i] = 30'h10 + 30'($urandom_range(0, 2));
                wayData[i] = $urandom;
            end
            loadWays(4'($urandom_range(0, 15)), tags);
            addr = {30'h10 + 30'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
            modelLookup(addr, ew, em);
            runTxn(addr, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, NW - 1), ew, em);
        end

        // Saturation: preload the hit counter just below its ceiling.
        wayValid = 4'b0001;
        wayTags[0 +: TW] = 30'h77;
        force dut.hitCount = 32'hFFFF_FFFE;
        #1;
        release dut.hitCount;
        mdlHit = 32'hFFFF_FFFE;
        for (int n = 0; n < 3; n++) runTxn(32'h0000_01DC, 0, 0, 0, 0, 1'b0);
        chk("hitCount_saturated", hitCount, 32'hFFFF_FFFF);

        // Reset while a response is being held.
        reqAddr = 32'h0000_01DC;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        tick();
        chk("pre_reset_rspValid", 32'(rspValid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_rsp_rspValid", 32'(rspValid), 32'd0);
        chk("rst_rsp_targetWay", 32'(targetWay), 32'd0);
        chk("rst_rsp_hitCount", hitCount, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset while waiting for a fill.
        wayValid = '0;
        reqAddr = 32'h0000_0700;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        tick();
        missReady = 1'b1;
        tick();
        missReady = 1'b0;
        chk("pre_reset_missCount", missCount, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_fill_missValid", 32'(missValid), 32'd0);
        chk("rst_fill_rspValid", 32'(rspValid), 32'd0);
        chk("rst_fill_targetWay", 32'(targetWay), 32'd0);
        chk("rst_fill_hitCount", hitCount, 32'd0);
        chk("rst_fill_missCount", missCount, 32'd0);
        chk("rst_fill_multiHitErr", 32'(multiHitErr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        mdlHit = '0;
        mdlMiss = '0;
        mdlMulti = 1'b0;
        wayValid = 4'b0100;
        wayTags[2*TW +: TW] = 30'h40;
        wayData[2] = 32'hDEAD_BEEF;
        runTxn(32'h0000_0100, 0, 0, 0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
